// File: rtl/parity_generator.sv
// Parity generation for a data word: combinational parity, a one-cycle registered
// protected word {parity, data}, and a checker with a saturating mismatch counter.
module parity_generator #(
    parameter int unsigned DATA_W     = 16,
    parameter bit          ODD_PARITY = 1'b0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [DATA_W-1:0] a_i,
    output logic              parity_o,
    input  logic              valid_i,
    output logic [DATA_W:0]   data_o,
    output logic              valid_o,
    input  logic              chk_valid_i,
    input  logic [DATA_W:0]   chk_i,
    output logic              err_o,
    output logic [CNT_W-1:0]  err_cnt_o,
    input  logic              err_clr_i
);

    logic chk_parity;
    logic mismatch;

    // Reduction XOR; synthesis balances it into a tree, no pipelining.
    always_comb begin
        parity_o   = (^a_i) ^ ODD_PARITY;
        chk_parity = (^chk_i[DATA_W-1:0]) ^ ODD_PARITY;
        mismatch   = (chk_parity != chk_i[DATA_W]);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_o  <= '0;
            valid_o <= 1'b0;
        end else begin
            valid_o <= valid_i;
            if (valid_i) begin
                data_o <= {parity_o, a_i};
            end
        end
    end

    // Clear wins over a simultaneous check; the counter sticks at all-ones.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_o     <= 1'b0;
            err_cnt_o <= '0;
        end else if (err_clr_i) begin
            err_o     <= 1'b0;
            err_cnt_o <= '0;
        end else if (chk_valid_i) begin
            err_o <= mismatch;
            if (mismatch && (err_cnt_o != '1)) begin
                err_cnt_o <= err_cnt_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_parity_generator.sv
// Self-checking bench: even/16-bit, odd/16-bit and even/2-bit-counter instances
// share stimulus and are compared against a behavioural model.
module tb_parity_generator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] a = '0;
    logic        valid = 1'b0;
    logic        chk_valid = 1'b0;
    logic [16:0] chk = '0;
    logic        err_clr = 1'b0;

    logic        p0, p1, p2;
    logic [16:0] d0, d1, d2;
    logic        v0, v1, v2;
    logic        e0, e1, e2;
    logic [15:0] c0, c1;
    logic [1:0]  c2;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    logic [16:0] m_data [3];
    logic        m_valid[3];
    logic        m_err  [3];
    int unsigned m_cnt  [3];
    bit          m_odd  [3] = '{1'b0, 1'b1, 1'b0};
    int unsigned m_max  [3] = '{65535, 65535, 3};

    always #5 clk = ~clk;

    parity_generator #(.DATA_W(16), .ODD_PARITY(1'b0), .CNT_W(16)) u_even (
        .clk_i(clk), .rst_ni(rst_n), .a_i(a), .parity_o(p0), .valid_i(valid),
        .data_o(d0), .valid_o(v0), .chk_valid_i(chk_valid), .chk_i(chk),
        .err_o(e0), .err_cnt_o(c0), .err_clr_i(err_clr));

    parity_generator #(.DATA_W(16), .ODD_PARITY(1'b1), .CNT_W(16)) u_odd (
        .clk_i(clk), .rst_ni(rst_n), .a_i(a), .parity_o(p1), .valid_i(valid),
        .data_o(d1), .valid_o(v1), .chk_valid_i(chk_valid), .chk_i(chk),
        .err_o(e1), .err_cnt_o(c1), .err_clr_i(err_clr));

    parity_generator #(.DATA_W(16), .ODD_PARITY(1'b0), .CNT_W(2)) u_sat (
        .clk_i(clk), .rst_ni(rst_n), .a_i(a), .parity_o(p2), .valid_i(valid),
        .data_o(d2), .valid_o(v2), .chk_valid_i(chk_valid), .chk_i(chk),
        .err_o(e2), .err_cnt_o(c2), .err_clr_i(err_clr));

    function automatic logic ref_par(input logic [15:0] x, input bit odd);
        return ((($countones(x) % 2) == 1) ? 1'b1 : 1'b0) ^ odd;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_data[k]  = '0;
            m_valid[k] = 1'b0;
            m_err[k]   = 1'b0;
            m_cnt[k]   = 0;
        end
    endtask

    task automatic model_edge();
        bit mm;
        for (int k = 0; k < 3; k++) begin
            m_valid[k] = valid;
            if (valid) m_data[k] = {ref_par(a, m_odd[k]), a};
            if (err_clr) begin
                m_err[k] = 1'b0;
                m_cnt[k] = 0;
            end else if (chk_valid) begin
                mm = (ref_par(chk[15:0], m_odd[k]) != chk[16]);
                m_err[k] = mm;
                if (mm && m_cnt[k] < m_max[k]) m_cnt[k]++;
            end
        end
    endtask

    task automatic check_all();
        check("par_even", p0, ref_par(a, 1'b0));
        check("par_odd",  p1, ref_par(a, 1'b1));
        check("par_sat",  p2, ref_par(a, 1'b0));
        check("data_even", d0, m_data[0]);
        check("data_odd",  d1, m_data[1]);
        check("data_sat",  d2, m_data[2]);
        check("valid_even", v0, m_valid[0]);
        check("valid_odd",  v1, m_valid[1]);
        check("valid_sat",  v2, m_valid[2]);
        check("err_even", e0, m_err[0]);
        check("err_odd",  e1, m_err[1]);
        check("err_sat",  e2, m_err[2]);
        check("cnt_even", c0, m_cnt[0]);
        check("cnt_odd",  c1, m_cnt[1]);
        check("cnt_sat",  c2, m_cnt[2]);
    endtask

    // One clock edge: update the model from the inputs the DUT samples, then compare.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();

        // Exhaustive sweep held in reset: parity is combinational and reset-independent.
        for (int i = 0; i < 65536; i++) begin
            a = 16'(i);
            #1;
            check("sweep_even", p0, ref_par(a, 1'b0));
            check("sweep_odd",  p1, ref_par(a, 1'b1));
            #9;
        end
        check("rst_data",  d0, 17'h0);
        check("rst_valid", v0, 1'b0);
        check("rst_err",   e0, 1'b0);
        check("rst_cnt",   c0, 16'h0);

        a = 16'h0000; #1; check("spot_0000", p0, 1'b0); check("odd_0000", p1, 1'b1);
        a = 16'h0001; #1; check("spot_0001", p0, 1'b1); check("odd_0001", p1, 1'b0);
        a = 16'h0003; #1; check("spot_0003", p0, 1'b0);
        a = 16'h8000; #1; check("spot_8000", p0, 1'b1);
        a = 16'h7FFF; #1; check("spot_7fff", p0, 1'b1);
        a = 16'hFFFF; #1; check("spot_ffff", p0, 1'b0);

        @(posedge clk); #1;
        rst_n = 1'b1;

        // Registered protected-word path.
        a = 16'h0007; valid = 1'b1;
        step();
        check("word_0007", d0, 17'h1_0007);
        check("word_valid", v0, 1'b1);
        a = 16'h1234; valid = 1'b0;
        step();
        check("word_hold", d0, 17'h1_0007);
        check("word_novalid", v0, 1'b0);

        // Checker: good word, bad word, clear beating a bad check.
        chk_valid = 1'b1; chk = 17'h1_0001;
        step();
        check("chk_good_err", e0, 1'b0);
        check("chk_good_cnt", c0, 16'd0);
        chk = 17'h0_0001;
        step();
        check("chk_bad_err", e0, 1'b1);
        check("chk_bad_cnt", c0, 16'd1);
        err_clr = 1'b1;
        step();
        check("clr_err", e0, 1'b0);
        check("clr_cnt", c0, 16'd0);
        err_clr = 1'b0;

        // Five bad words: the 2-bit counter saturates at 3.
        for (int i = 0; i < 5; i++) step();
        check("sat_cnt2", c2, 2'd3);
        check("sat_cnt16", c0, 16'd5);

        // Build up valid_o=1 and count=2, then reset between edges.
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        valid = 1'b1; a = 16'h00F1;
        step();
        step();
        check("pre_rst_cnt", c0, 16'd2);
        check("pre_rst_valid", v0, 1'b1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("mid_rst_data", d0, 17'h0);
        check("mid_rst_valid", v0, 1'b0);
        check("mid_rst_err", e0, 1'b0);
        check("mid_rst_cnt", c0, 16'd0);
        a = 16'h0101; #1;
        check("rst_par_a", p0, ref_par(a, 1'b0));
        a = 16'h0100; #1;
        check("rst_par_b", p0, ref_par(a, 1'b0));
        valid = 1'b0; chk_valid = 1'b0;
        @(posedge clk); #1;
        check_all();
        rst_n = 1'b1;
        step();
        valid = 1'b1; a = 16'hBEEF;
        step();
        check("post_rst_word", d0, {ref_par(16'hBEEF, 1'b0), 16'hBEEF});

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            a         = 16'($urandom);
            valid     = 1'($urandom_range(0, 1));
            chk_valid = 1'($urandom_range(0, 1));
            chk       = 17'($urandom);
            err_clr   = ($urandom_range(0, 19) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
